// File: rtl/decode_wb_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids, status codes and stage FSM states.
package decode_wb_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREG   = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/decode_wb_regfile.sv
// Register file: NREG entries, two bypassed combinational read ports, two write ports with M priority.
module decode_wb_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [3:0]        rd_a_idx,
  output logic [DATA_W-1:0] rd_a_data_c,
  input  logic [3:0]        rd_b_idx,
  output logic [DATA_W-1:0] rd_b_data_c,
  input  logic [3:0]        wr_e_idx,
  input  logic [DATA_W-1:0] wr_e_data,
  input  logic [3:0]        wr_m_idx,
  input  logic [DATA_W-1:0] wr_m_data
);
  import decode_wb_pkg::*;

  logic [DATA_W-1:0] regs [NREG];

  // Index RNONE never matches a storage slot, so it is ignored on writes.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!rst_n_i) begin
        regs[i] <= '0;
      end else if (wr_m_idx == 4'(i)) begin
        regs[i] <= wr_m_data;
      end else if (wr_e_idx == 4'(i)) begin
        regs[i] <= wr_e_data;
      end
    end
  end

  // Reads see same-cycle writes; M overrides E, RNONE reads as zero.
  always_comb begin
    rd_a_data_c = '0;
    rd_b_data_c = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (rd_a_idx == 4'(i)) rd_a_data_c = regs[i];
      if (rd_b_idx == 4'(i)) rd_b_data_c = regs[i];
    end
    if (rd_a_idx != RNONE && rd_a_idx == wr_e_idx) rd_a_data_c = wr_e_data;
    if (rd_a_idx != RNONE && rd_a_idx == wr_m_idx) rd_a_data_c = wr_m_data;
    if (rd_b_idx != RNONE && rd_b_idx == wr_e_idx) rd_b_data_c = wr_e_data;
    if (rd_b_idx != RNONE && rd_b_idx == wr_m_idx) rd_b_data_c = wr_m_data;
  end

endmodule

// File: rtl/decode_wb.sv
// Y86-64 decode/writeback stage: decodes fetch bundles, reads operands and
// presents a registered valid/ready bundle to execute; accepts writebacks.
module decode_wb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15,
  parameter int unsigned RSP_ID = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifun_i,
  input  logic [3:0]        rA_i,
  input  logic [3:0]        rB_i,
  input  logic [DATA_W-1:0] valC_i,
  input  logic [DATA_W-1:0] valP_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [3:0]        icode_o,
  output logic [3:0]        ifun_o,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  output logic [DATA_W-1:0] valC_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o,
  output logic [2:0]        stat_o,
  input  logic [3:0]        wb_dstE_i,
  input  logic [DATA_W-1:0] wb_valE_i,
  input  logic [3:0]        wb_dstM_i,
  input  logic [DATA_W-1:0] wb_valM_i
);
  import decode_wb_pkg::*;

  localparam logic [3:0] RSP_IDX = 4'(RSP_ID);

  state_e            state_q, state_d;
  logic              capture_c;
  logic [3:0]        src_a_c, src_b_c, dst_e_c, dst_m_c;
  logic [2:0]        stat_c;
  logic [DATA_W-1:0] rf_a_c, rf_b_c, val_a_c;

  decode_wb_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rd_a_idx   (src_a_c),
    .rd_a_data_c(rf_a_c),
    .rd_b_idx   (src_b_c),
    .rd_b_data_c(rf_b_c),
    .wr_e_idx   (wb_dstE_i),
    .wr_e_data  (wb_valE_i),
    .wr_m_idx   (wb_dstM_i),
    .wr_m_data  (wb_valM_i)
  );

  assign in_ready_o = (state_q == RUN) && (!out_valid_o || out_ready_i);
  assign capture_c  = in_valid_i && in_ready_o;

  // Register source/destination decode.
  always_comb begin
    src_a_c = RNONE;
    src_b_c = RNONE;
    dst_e_c = RNONE;
    dst_m_c = RNONE;
    case (icode_i)
      IRRMOVQ: begin src_a_c = rA_i;    dst_e_c = rB_i; end
      IIRMOVQ: begin dst_e_c = rB_i; end
      IRMMOVQ: begin src_a_c = rA_i;    src_b_c = rB_i; end
      IMRMOVQ: begin src_b_c = rB_i;    dst_m_c = rA_i; end
      IOPQ:    begin src_a_c = rA_i;    src_b_c = rB_i;    dst_e_c = rB_i; end
      ICALL:   begin src_b_c = RSP_IDX; dst_e_c = RSP_IDX; end
      IRET:    begin src_a_c = RSP_IDX; src_b_c = RSP_IDX; dst_e_c = RSP_IDX; end
      IPUSHQ:  begin src_a_c = rA_i;    src_b_c = RSP_IDX; dst_e_c = RSP_IDX; end
      IPOPQ:   begin src_a_c = RSP_IDX; src_b_c = RSP_IDX; dst_e_c = RSP_IDX; dst_m_c = rA_i; end
      default: ;
    endcase
  end

  always_comb begin
    stat_c = SAOK;
    if (icode_i == IHALT)     stat_c = SHLT;
    else if (icode_i > IPOPQ) stat_c = SINS;
    val_a_c = (icode_i == IJXX || icode_i == ICALL) ? valP_i : rf_a_c;
  end

  // Stage FSM: any non-AOK bundle freezes intake until reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && capture_c && stat_c != SAOK) state_d = HALTED;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      icode_o     <= INOP;
      ifun_o      <= 4'h0;
      valA_o      <= '0;
      valB_o      <= '0;
      valC_o      <= '0;
      dstE_o      <= RNONE;
      dstM_o      <= RNONE;
      stat_o      <= SAOK;
    end else if (capture_c) begin
      out_valid_o <= 1'b1;
      ifun_o      <= ifun_i;
      valA_o      <= val_a_c;
      valB_o      <= rf_b_c;
      valC_o      <= valC_i;
      stat_o      <= stat_c;
      // Illegal instructions travel on as a NOP with no register effects.
      if (stat_c == SINS) begin
        icode_o <= INOP;
        dstE_o  <= RNONE;
        dstM_o  <= RNONE;
      end else begin
        icode_o <= icode_i;
        dstE_o  <= dst_e_c;
        dstM_o  <= dst_m_c;
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_wb.sv
// Directed bench for decode_wb: vector table for decode/operand read, plus
// hand sequences for backpressure, halt, illegal instruction and reset.
module tb_decode_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  icode, ifun, ra, rb, wb_dste, wb_dstm;
  logic [63:0] valc, valp, wb_vale, wb_valm;
  logic [3:0]  icode_o, ifun_o, dste_o, dstm_o;
  logic [63:0] vala_o, valb_o, valc_o;
  logic [2:0]  stat_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decode_wb dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .icode_i(icode), .ifun_i(ifun), .rA_i(ra), .rB_i(rb),
    .valC_i(valc), .valP_i(valp),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .icode_o(icode_o), .ifun_o(ifun_o),
    .valA_o(vala_o), .valB_o(valb_o), .valC_o(valc_o),
    .dstE_o(dste_o), .dstM_o(dstm_o), .stat_o(stat_o),
    .wb_dstE_i(wb_dste), .wb_valE_i(wb_vale),
    .wb_dstM_i(wb_dstm), .wb_valM_i(wb_valm)
  );

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [3:0]  wbe;
    logic [63:0] vale;
    logic [3:0]  wbm;
    logic [63:0] valm;
    logic [3:0]  e_icode;
    logic [63:0] e_vala, e_valb;
    logic [3:0]  e_dste, e_dstm;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [63:0] c, input logic [63:0] p,
                              input logic [3:0] we, input logic [63:0] ve,
                              input logic [3:0] wm, input logic [63:0] vm,
                              input logic [63:0] ea, input logic [63:0] eb,
                              input logic [3:0] ee, input logic [3:0] em);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.ra = a; v.rb = b; v.valc = c; v.valp = p;
    v.wbe = we; v.vale = ve; v.wbm = wm; v.valm = vm;
    v.e_icode = ic; v.e_vala = ea; v.e_valb = eb; v.e_dste = ee; v.e_dstm = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wb();
    wb_dste = 4'hF; wb_vale = '0; wb_dstm = 4'hF; wb_valm = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Regs at table start: r3=0x10, r4=0x100; popq row makes r4=0x55; r1 written by last row.
    vecs[0]  = mk(4'h6, 4'h0, 4'h3, 4'h3, 64'h0,    64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h10,  64'h10,  4'h3, 4'hF);
    vecs[1]  = mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h77,   64'h40, 4'hF, 64'h0,   4'hF, 64'h0,  64'h40,  64'h100, 4'h4, 4'hF);
    vecs[2]  = mk(4'h3, 4'h0, 4'hF, 4'h2, 64'h1234, 64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h0,   64'h0,   4'h2, 4'hF);
    vecs[3]  = mk(4'hB, 4'h0, 4'h4, 4'hF, 64'h0,    64'h0,  4'h4, 64'h108, 4'h4, 64'h55, 64'h55,  64'h55,  4'h4, 4'h4);
    vecs[4]  = mk(4'h5, 4'h0, 4'h1, 4'h4, 64'h8,    64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h0,   64'h55,  4'hF, 4'h1);
    vecs[5]  = mk(4'h2, 4'h3, 4'h3, 4'h7, 64'h0,    64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h10,  64'h0,   4'h7, 4'hF);
    vecs[6]  = mk(4'hA, 4'h0, 4'h3, 4'hF, 64'h0,    64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h10,  64'h55,  4'h4, 4'hF);
    vecs[7]  = mk(4'h4, 4'h0, 4'h3, 4'h4, 64'h18,   64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h10,  64'h55,  4'hF, 4'hF);
    vecs[8]  = mk(4'h9, 4'h0, 4'hF, 4'hF, 64'h0,    64'h0,  4'hF, 64'h0,   4'hF, 64'h0,  64'h55,  64'h55,  4'h4, 4'hF);
    vecs[9]  = mk(4'h7, 4'h1, 4'hF, 4'hF, 64'h200,  64'h50, 4'hF, 64'h0,   4'hF, 64'h0,  64'h50,  64'h0,   4'hF, 4'hF);
    vecs[10] = mk(4'h6, 4'h1, 4'h1, 4'h1, 64'h0,    64'h0,  4'h1, 64'hAA,  4'hF, 64'h0,  64'hAA,  64'hAA,  4'h1, 4'hF);

    in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; ra = 4'hF; rb = 4'hF; valc = '0; valp = '0;
    idle_wb();
    do_reset();

    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_icode", 64'(icode_o), 64'h1);
    chk("rst_ifun", 64'(ifun_o), 64'h0);
    chk("rst_vala", vala_o, 64'h0);
    chk("rst_valb", valb_o, 64'h0);
    chk("rst_valc", valc_o, 64'h0);
    chk("rst_dste", 64'(dste_o), 64'hF);
    chk("rst_dstm", 64'(dstm_o), 64'hF);
    chk("rst_stat", 64'(stat_o), 64'h1);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Preload r3=0x10 via E and %rsp=0x100 via M.
    wb_dste = 4'h3; wb_vale = 64'h10; wb_dstm = 4'h4; wb_valm = 64'h100;
    step();
    idle_wb();

    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      icode = vecs[i].icode; ifun = vecs[i].ifun; ra = vecs[i].ra; rb = vecs[i].rb;
      valc = vecs[i].valc; valp = vecs[i].valp;
      wb_dste = vecs[i].wbe; wb_vale = vecs[i].vale;
      wb_dstm = vecs[i].wbm; wb_valm = vecs[i].valm;
      step();
      idle_wb();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'h1);
      chk($sformatf("v%0d_icode", i), 64'(icode_o), 64'(vecs[i].e_icode));
      chk($sformatf("v%0d_ifun", i), 64'(ifun_o), 64'(vecs[i].ifun));
      chk($sformatf("v%0d_vala", i), vala_o, vecs[i].e_vala);
      chk($sformatf("v%0d_valb", i), valb_o, vecs[i].e_valb);
      chk($sformatf("v%0d_valc", i), valc_o, vecs[i].valc);
      chk($sformatf("v%0d_dste", i), 64'(dste_o), 64'(vecs[i].e_dste));
      chk($sformatf("v%0d_dstm", i), 64'(dstm_o), 64'(vecs[i].e_dstm));
      chk($sformatf("v%0d_stat", i), 64'(stat_o), 64'h1);
    end

    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 64'(out_valid), 64'h0);

    // Backpressure: bundle X held for 3 cycles while bundle Y waits.
    in_valid = 1'b1; out_ready = 1'b0;
    icode = 4'h6; ifun = 4'h0; ra = 4'h3; rb = 4'h3;
    step();
    chk("bp_x_valid", 64'(out_valid), 64'h1);
    icode = 4'h2; ifun = 4'h0; ra = 4'h1; rb = 4'h5;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'h0);
      step();
      chk($sformatf("bp%0d_valid", k), 64'(out_valid), 64'h1);
      chk($sformatf("bp%0d_icode", k), 64'(icode_o), 64'h6);
      chk($sformatf("bp%0d_dste", k), 64'(dste_o), 64'h3);
      chk($sformatf("bp%0d_vala", k), vala_o, 64'h10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_y_valid", 64'(out_valid), 64'h1);
    chk("bp_y_icode", 64'(icode_o), 64'h2);
    chk("bp_y_dste", 64'(dste_o), 64'h5);
    chk("bp_y_vala", vala_o, 64'hAA);
    in_valid = 1'b0;
    step();
    chk("bp_no_dup", 64'(out_valid), 64'h0);

    // Halt: stat=HLT, intake closed, drains, writebacks continue.
    in_valid = 1'b1; icode = 4'h0; ra = 4'hF; rb = 4'hF;
    step();
    chk("hlt_valid", 64'(out_valid), 64'h1);
    chk("hlt_stat", 64'(stat_o), 64'h2);
    chk("hlt_icode", 64'(icode_o), 64'h0);
    chk("hlt_in_ready", 64'(in_ready), 64'h0);
    icode = 4'h6; ra = 4'h3; rb = 4'h3;
    wb_dste = 4'h6; wb_vale = 64'h66;
    step();
    idle_wb();
    chk("hlt_drained", 64'(out_valid), 64'h0);
    chk("hlt_in_ready_stuck", 64'(in_ready), 64'h0);
    chk("hlt_stat_hold", 64'(stat_o), 64'h2);
    chk("hlt_wb_r6", dut.u_rf.regs[6], 64'h66);
    in_valid = 1'b0;
    do_reset();
    chk("hlt_rst_stat", 64'(stat_o), 64'h1);
    chk("hlt_rst_in_ready", 64'(in_ready), 64'h1);
    chk("hlt_rst_r6", dut.u_rf.regs[6], 64'h0);

    // Illegal instruction, then reset with the bundle still held.
    in_valid = 1'b1; out_ready = 1'b1; icode = 4'hD; ifun = 4'h0; ra = 4'h1; rb = 4'h2;
    step();
    chk("ins_valid", 64'(out_valid), 64'h1);
    chk("ins_stat", 64'(stat_o), 64'h4);
    chk("ins_icode", 64'(icode_o), 64'h1);
    chk("ins_dste", 64'(dste_o), 64'hF);
    chk("ins_dstm", 64'(dstm_o), 64'hF);
    chk("ins_in_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("ins_held", 64'(out_valid), 64'h1);
    do_reset();
    chk("ins_rst_valid", 64'(out_valid), 64'h0);
    chk("ins_rst_stat", 64'(stat_o), 64'h1);
    chk("ins_rst_icode", 64'(icode_o), 64'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
